// File: rtl/port_responder_pkg.sv
// Shared types for port_responder.
//   state_t : responder state machine encoding
//   cmd_t   : one captured port command (address, byte enables, write, data)
// The command address field is sized for the widest supported AW; narrower
// instances zero-fill the upper bits.
package port_responder_pkg;

  localparam int unsigned AW_MAX      = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  typedef struct packed {
    logic [AW_MAX-1:0] a;
    logic [1:0]        ds;
    logic              we;
    logic [15:0]       d;
  } cmd_t;

endpackage

// File: rtl/port_cmd_skid.sv
// One-entry holding slot for a command that arrives while an access is active.
//   clk, reset : clock, asynchronous active-low reset
//   load       : write din into the slot (allowed together with pop)
//   pop        : release the slot contents
//   din, dout  : command in / held command out
//   full       : slot holds a command
module port_cmd_skid
  import port_responder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      // load with pop refills the slot in the same cycle it drains
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/port_responder.sv
// Toggle-handshake port to ready/valid memory backend bridge.
//   clk, reset                      : clock, asynchronous active-low reset
//   port_req / port_ack             : toggle request in, toggle completion out
//   port_a/ds/we/d, port_q          : command fields in, last read data out
//   mem_cs/we/a/be/wdata            : backend request (held stable until ready)
//   mem_rdata, mem_rdy              : backend read data and ready
//   busy                            : access active or command pending
//   err_to, err_ovr, err_clr        : sticky timeout / overrun flags and clear
module port_responder
  import port_responder_pkg::*;
#(
  parameter int unsigned AW      = 23,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [15:0]   port_d,
  output logic [15:0]   port_q,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_be,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_rdy,
  output logic          busy,
  output logic          err_to,
  output logic          err_ovr,
  input  logic          err_clr
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t     state;
  logic       req_s;
  logic       primed;
  logic [7:0] wait_cnt;

  logic edge_det, in_access, xfer, timeout, done, start, overrun;
  logic slot_full, slot_load, slot_pop;
  cmd_t cmd_in, slot_q;

  logic [AW-1:0] nxt_a;
  logic [1:0]    nxt_ds;
  logic          nxt_we;
  logic [15:0]   nxt_d;

  always_comb begin
    cmd_in          = '0;
    cmd_in.a[AW-1:0] = port_a;
    cmd_in.ds       = port_ds;
    cmd_in.we       = port_we;
    cmd_in.d        = port_d;
  end

  // primed suppresses a false edge on the first cycle out of reset
  assign edge_det  = primed && (req_s != port_req);
  assign in_access = (state == ST_ACCESS);
  assign xfer      = in_access && mem_cs && mem_rdy;
  assign timeout   = in_access && mem_cs && !mem_rdy && (wait_cnt == TO_LIMIT);
  // an access with no byte enables never drives mem_cs and finishes at once
  assign done      = xfer || timeout || (in_access && !mem_cs);

  // Edge during access: park in the slot unless the active command is
  // finishing with the slot empty, in which case it goes straight to active.
  assign slot_pop  = done && slot_full;
  assign slot_load = edge_det && in_access && (done ? slot_full : !slot_full);
  assign overrun   = edge_det && in_access && !done && slot_full;
  assign start     = (edge_det && (!in_access || done)) || slot_pop;

  assign nxt_a  = slot_pop ? slot_q.a[AW-1:0] : port_a;
  assign nxt_ds = slot_pop ? slot_q.ds        : port_ds;
  assign nxt_we = slot_pop ? slot_q.we        : port_we;
  assign nxt_d  = slot_pop ? slot_q.d         : port_d;

  port_cmd_skid u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (slot_load),
    .pop   (slot_pop),
    .din   (cmd_in),
    .dout  (slot_q),
    .full  (slot_full)
  );

  generate
    if (AW < AW_MAX) begin : g_addr_pad
      logic unused_addr_hi;
      assign unused_addr_hi = |slot_q.a[AW_MAX-1:AW];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_s     <= 1'b0;
      primed    <= 1'b0;
      wait_cnt  <= '0;
      port_ack  <= 1'b0;
      port_q    <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      err_to    <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      req_s  <= port_req;
      primed <= 1'b1;

      if (done) port_ack <= !port_ack;
      if (xfer && !mem_we) port_q <= mem_rdata;

      if (start) begin
        state     <= ST_ACCESS;
        busy      <= 1'b1;
        mem_cs    <= |nxt_ds;
        mem_we    <= nxt_we;
        mem_a     <= nxt_a;
        mem_be    <= nxt_ds;
        mem_wdata <= nxt_d;
        wait_cnt  <= '0;
      end else if (done) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        mem_cs   <= 1'b0;
        wait_cnt <= '0;
      end else if (in_access && mem_cs) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // a set event in the same cycle as err_clr keeps the flag set
      if (timeout)      err_to <= 1'b1;
      else if (err_clr) err_to <= 1'b0;

      if (overrun)      err_ovr <= 1'b1;
      else if (err_clr) err_ovr <= 1'b0;
    end
  end

endmodule
